// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module : game_pkg
// Brief  : Shared types, default frame constants and BCD helpers for game_ctrl.
// Rev    : 1.0 - initial release
// ============================================================================
package game_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READY = 2'b01,
        PLAY  = 2'b10,
        OVER  = 2'b11
    } game_state_t;

    typedef logic [11:0] bcd3_t;

    localparam int    c_ready_frames_dflt = 90;
    localparam int    c_over_hold_dflt    = 60;
    localparam int    c_frame_cnt_w       = 7;
    localparam bcd3_t c_bcd_max           = 12'h999;

    // Digit-wise BCD magnitude compare, most significant digit decides first.
    function automatic logic bcd_gt(input bcd3_t a, input bcd3_t b);
        logic decided;
        logic gt;
        decided = 1'b0;
        gt      = 1'b0;
        for (int i = 2; i >= 0; i--) begin
            if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
                gt      = (a[4*i +: 4] > b[4*i +: 4]);
                decided = 1'b1;
            end
        end
        return gt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_counter3.sv
`default_nettype none
// ============================================================================
// Module : bcd_counter3
// Brief  : Three-digit BCD counter with clear, increment and hold at 999.
// Rev    : 1.0 - initial release
// ============================================================================
module bcd_counter3
    import game_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_clear,
    input  logic  i_inc,
    output bcd3_t o_count
);

    bcd3_t r_count;
    bcd3_t w_next;

    always_comb begin
        w_next = r_count;
        if (r_count != c_bcd_max) begin
            if (r_count[3:0] != 4'd9) begin
                w_next[3:0] = r_count[3:0] + 4'd1;
            end else begin
                w_next[3:0] = 4'd0;
                if (r_count[7:4] != 4'd9) begin
                    w_next[7:4] = r_count[7:4] + 4'd1;
                end else begin
                    w_next[7:4]  = 4'd0;
                    w_next[11:8] = r_count[11:8] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= w_next;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
// Module : game_ctrl
// Brief  : Flappy Bird sequencer: frame strobe, flap/hit latches, FSM, scores.
// Rev    : 1.0 - initial release
// ============================================================================
module game_ctrl
    import game_pkg::*;
#(
    parameter int READY_FRAMES     = c_ready_frames_dflt,
    parameter int OVER_HOLD_FRAMES = c_over_hold_dflt,
    parameter int VS_ACTIVE_LOW    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vs,
    input  logic        flap_key,
    input  logic        collision,
    input  logic        pipe_passed,
    output game_state_t state,
    output logic        frame_tick,
    output logic        flap_strobe,
    output logic        game_init,
    output bcd3_t       score,
    output bcd3_t       best
);

    localparam logic [1:0] c_st_idle  = IDLE;
    localparam logic [1:0] c_st_ready = READY;
    localparam logic [1:0] c_st_play  = PLAY;
    localparam logic [1:0] c_st_over  = OVER;

    localparam logic [c_frame_cnt_w-1:0] c_ready_last = c_frame_cnt_w'(READY_FRAMES - 1);
    localparam logic [c_frame_cnt_w-1:0] c_over_hold  = c_frame_cnt_w'(OVER_HOLD_FRAMES);
    localparam logic c_vs_act_level = (VS_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

    logic                     r_vs_act_q;
    logic                     r_frame_tick;
    logic                     r_flap_pend;
    logic                     r_hit_pend;
    logic [1:0]               r_state;
    logic [c_frame_cnt_w-1:0] r_frame_cnt;
    logic                     r_game_init;
    logic                     r_best_upd;
    bcd3_t                    r_best;

    logic                     w_vs_act;
    logic                     w_vs_edge;
    logic [1:0]               w_state_nxt;
    logic                     w_init;
    logic                     w_state_chg;
    logic                     w_score_clr;
    logic                     w_score_inc;
    bcd3_t                    w_score;

    // Held as an "active" flag so polarity is resolved once at the input.
    assign w_vs_act  = (vs == c_vs_act_level);
    assign w_vs_edge = w_vs_act & ~r_vs_act_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs_act_q   <= 1'b0;
            r_frame_tick <= 1'b0;
            r_flap_pend  <= 1'b0;
            r_hit_pend   <= 1'b0;
        end else begin
            r_vs_act_q   <= w_vs_act;
            r_frame_tick <= w_vs_edge;
            // Requests arriving on the tick cycle itself carry into the next frame.
            r_flap_pend  <= r_frame_tick ? flap_key  : (r_flap_pend | flap_key);
            r_hit_pend   <= r_frame_tick ? collision : (r_hit_pend  | collision);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_init      = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (r_frame_tick && r_flap_pend) begin
                    w_state_nxt = c_st_ready;
                    w_init      = 1'b1;
                end
            end
            c_st_ready: begin
                if (r_frame_tick && (r_frame_cnt == c_ready_last)) begin
                    w_state_nxt = c_st_play;
                end
            end
            c_st_play: begin
                if (r_frame_tick && r_hit_pend) begin
                    w_state_nxt = c_st_over;
                end
            end
            c_st_over: begin
                if (r_frame_tick && (r_frame_cnt >= c_over_hold) && r_flap_pend) begin
                    w_state_nxt = c_st_ready;
                    w_init      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    assign w_state_chg = (w_state_nxt != r_state);
    assign w_score_clr = w_state_chg && (w_state_nxt == c_st_ready);
    assign w_score_inc = pipe_passed && (r_state == c_st_play);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_frame_cnt <= '0;
            r_game_init <= 1'b0;
            r_best_upd  <= 1'b0;
            r_best      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_game_init <= w_init;
            r_best_upd  <= w_state_chg && (w_state_nxt == c_st_over);
            // Counter holds at all-ones so a long OVER stay never wraps below the hold.
            if (w_state_chg) begin
                r_frame_cnt <= '0;
            end else if (r_frame_tick && (r_frame_cnt != '1)) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
            if (r_best_upd && bcd_gt(w_score, r_best)) begin
                r_best <= w_score;
            end
        end
    end

    bcd_counter3 u_score (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_score_clr),
        .i_inc   (w_score_inc),
        .o_count (w_score)
    );

    assign state       = game_state_t'(r_state);
    assign frame_tick  = r_frame_tick;
    assign flap_strobe = r_frame_tick && (r_state == c_st_play) && r_flap_pend && !r_hit_pend;
    assign game_init   = r_game_init;
    assign score       = w_score;
    assign best        = r_best;

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_game_ctrl
// Brief  : Scoreboard bench for game_ctrl: frame ticks, FSM flow, scores.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_game_ctrl;
    import game_pkg::*;

    localparam logic c_vs_on  = 1'b0;
    localparam logic c_vs_off = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic        vs;
    logic        flap_key;
    logic        collision;
    logic        pipe_passed;
    game_state_t state;
    logic        frame_tick;
    logic        flap_strobe;
    logic        game_init;
    bcd3_t       score;
    bcd3_t       best;

    int errors  = 0;
    int checks  = 0;
    int n_ticks = 0;
    int m_score = 0;

    typedef struct packed {
        logic       strobe;
        logic       init;
        logic [1:0] nxt;
    } tick_exp_t;

    tick_exp_t tick_q[$];
    bcd3_t     score_q[$];

    always #5 clk = ~clk;

    game_ctrl #(
        .READY_FRAMES     (90),
        .OVER_HOLD_FRAMES (60),
        .VS_ACTIVE_LOW    (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .vs          (vs),
        .flap_key    (flap_key),
        .collision   (collision),
        .pipe_passed (pipe_passed),
        .state       (state),
        .frame_tick  (frame_tick),
        .flap_strobe (flap_strobe),
        .game_init   (game_init),
        .score       (score),
        .best        (best)
    );

    function automatic bcd3_t to_bcd(input int n);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    // Output monitor: pops tick and score expectations as the DUT produces them.
    tick_exp_t pend;
    logic      pend_vld  = 1'b0;
    logic      prev_tick = 1'b0;
    logic      pp_prev   = 1'b0;
    bcd3_t     exp_score;

    always @(negedge clk) begin
        if (rst) begin
            pend_vld  = 1'b0;
            prev_tick = 1'b0;
            pp_prev   = 1'b0;
        end else begin
            checks++;
            if (pend_vld) begin
                if (state !== pend.nxt) begin
                    errors++;
                    $display("FAIL tick_state: state=%0d expected=%0d at %0t", state, pend.nxt, $time);
                end
                checks++;
                if (game_init !== pend.init) begin
                    errors++;
                    $display("FAIL tick_init: game_init=%b expected=%b at %0t", game_init, pend.init, $time);
                end
                pend_vld = 1'b0;
            end else if (game_init !== 1'b0) begin
                errors++;
                $display("FAIL stray_init: game_init=%b expected=0 at %0t", game_init, $time);
            end
            if (frame_tick === 1'b1) begin
                n_ticks++;
                checks++;
                if (prev_tick !== 1'b0) begin
                    errors++;
                    $display("FAIL tick_width: frame_tick high 2+ cycles expected 1 at %0t", $time);
                end
                checks++;
                if (tick_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_tick: frame_tick=1 expected=0 at %0t", $time);
                end else begin
                    pend     = tick_q.pop_front();
                    pend_vld = 1'b1;
                    if (flap_strobe !== pend.strobe) begin
                        errors++;
                        $display("FAIL flap_strobe: got=%b expected=%b at %0t", flap_strobe, pend.strobe, $time);
                    end
                end
            end else begin
                checks++;
                if (flap_strobe !== 1'b0) begin
                    errors++;
                    $display("FAIL stray_strobe: flap_strobe=%b expected=0 at %0t", flap_strobe, $time);
                end
            end
            prev_tick = frame_tick;
            if (pp_prev) begin
                checks++;
                if (score_q.size() == 0) begin
                    errors++;
                    $display("FAIL score_queue: no expectation for score=%h at %0t", score, $time);
                end else begin
                    exp_score = score_q.pop_front();
                    if (score !== exp_score) begin
                        errors++;
                        $display("FAIL score_inc: score=%h expected=%h at %0t", score, exp_score, $time);
                    end
                end
            end
            pp_prev = pipe_passed;
        end
    end

    task automatic drive_frame(input logic exp_strobe, input logic exp_init,
                               input logic [1:0] exp_nxt, input logic flap_on_tick);
        tick_exp_t e;
        e.strobe = exp_strobe;
        e.init   = exp_init;
        e.nxt    = exp_nxt;
        tick_q.push_back(e);
        @(posedge clk) #1 vs = c_vs_on;
        @(posedge clk) #1 flap_key = flap_on_tick;
        @(posedge clk) #1 flap_key = 1'b0;
        repeat (2) @(posedge clk);
        #1 vs = c_vs_off;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic pulse_flap();
        @(posedge clk) #1 flap_key = 1'b1;
        @(posedge clk) #1 flap_key = 1'b0;
    endtask

    task automatic pulse_collision();
        @(posedge clk) #1 collision = 1'b1;
        @(posedge clk) #1 collision = 1'b0;
    endtask

    task automatic pulse_pp(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk) #1 pipe_passed = 1'b1;
            m_score = (m_score < 999) ? m_score + 1 : 999;
            score_q.push_back(to_bcd(m_score));
        end
        @(posedge clk) #1 pipe_passed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic to_play();
        for (int i = 0; i < 89; i++) drive_frame(1'b0, 1'b0, READY, 1'b0);
        drive_frame(1'b0, 1'b0, PLAY, 1'b0);
    endtask

    task automatic test_reset();
        int t0;
        rst = 1'b1; vs = c_vs_off; flap_key = 1'b0; collision = 1'b0; pipe_passed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (state !== IDLE)       begin errors++; $display("FAIL rst_state: got=%0d expected=0", state); end
        checks++; if (frame_tick !== 1'b0)  begin errors++; $display("FAIL rst_tick: got=%b expected=0", frame_tick); end
        checks++; if (flap_strobe !== 1'b0) begin errors++; $display("FAIL rst_strobe: got=%b expected=0", flap_strobe); end
        checks++; if (game_init !== 1'b0)   begin errors++; $display("FAIL rst_init: got=%b expected=0", game_init); end
        checks++; if (score !== 12'h000)    begin errors++; $display("FAIL rst_score: got=%h expected=000", score); end
        checks++; if (best !== 12'h000)     begin errors++; $display("FAIL rst_best: got=%h expected=000", best); end
        rst = 1'b0;
        m_score = 0;
        t0 = n_ticks;
        for (int i = 0; i < 3; i++) drive_frame(1'b0, 1'b0, IDLE, 1'b0);
        checks++; if (n_ticks - t0 != 3) begin errors++; $display("FAIL tick_count: got=%0d expected=3", n_ticks - t0); end
        checks++; if (state !== IDLE) begin errors++; $display("FAIL idle_hold: state=%0d expected=0", state); end
    endtask

    task automatic test_start_and_flap();
        pulse_flap();
        drive_frame(1'b0, 1'b1, READY, 1'b0);
        to_play();
        pulse_flap();
        drive_frame(1'b1, 1'b0, PLAY, 1'b0);
        drive_frame(1'b0, 1'b0, PLAY, 1'b0);
    endtask

    task automatic test_score_best();
        pulse_pp(12);
        checks++; if (score !== 12'h012) begin errors++; $display("FAIL score_12: got=%h expected=012", score); end
        pulse_collision();
        pulse_flap();
        drive_frame(1'b0, 1'b0, OVER, 1'b0);
        checks++; if (best !== 12'h012)  begin errors++; $display("FAIL best_update: got=%h expected=012", best); end
        checks++; if (score !== 12'h012) begin errors++; $display("FAIL score_frozen: got=%h expected=012", score); end
    endtask

    task automatic test_over_hold();
        for (int i = 0; i < 10; i++) drive_frame(1'b0, 1'b0, OVER, 1'b0);
        pulse_flap();
        drive_frame(1'b0, 1'b0, OVER, 1'b0);
        for (int i = 0; i < 50; i++) drive_frame(1'b0, 1'b0, OVER, 1'b0);
        pulse_flap();
        drive_frame(1'b0, 1'b1, READY, 1'b0);
        m_score = 0;
        checks++; if (score !== 12'h000) begin errors++; $display("FAIL ready_clear: score=%h expected=000", score); end
        checks++; if (best !== 12'h012)  begin errors++; $display("FAIL best_kept: got=%h expected=012", best); end
    endtask

    task automatic test_saturation();
        to_play();
        pulse_pp(998);
        checks++; if (score !== 12'h998) begin errors++; $display("FAIL score_998: got=%h expected=998", score); end
        pulse_pp(3);
        checks++; if (score !== 12'h999) begin errors++; $display("FAIL score_sat: got=%h expected=999", score); end
    endtask

    task automatic test_reset_mid_game();
        @(posedge clk) #1 rst = 1'b1;
        @(posedge clk) #1;
        checks++; if (state !== IDLE)    begin errors++; $display("FAIL mid_rst_state: got=%0d expected=0", state); end
        checks++; if (score !== 12'h000) begin errors++; $display("FAIL mid_rst_score: got=%h expected=000", score); end
        checks++; if (best !== 12'h000)  begin errors++; $display("FAIL mid_rst_best: got=%h expected=000", best); end
        rst = 1'b0;
        m_score = 0;
        pulse_flap();
        drive_frame(1'b0, 1'b1, READY, 1'b0);
        to_play();
        drive_frame(1'b0, 1'b0, PLAY, 1'b1);
        drive_frame(1'b1, 1'b0, PLAY, 1'b0);
        drive_frame(1'b0, 1'b0, PLAY, 1'b0);
    endtask

    initial begin
        test_reset();
        test_start_and_flap();
        test_score_best();
        test_over_hold();
        test_saturation();
        test_reset_mid_game();
        repeat (4) @(posedge clk);
        checks++; if (tick_q.size() != 0)  begin errors++; $display("FAIL tick_queue_left: got=%0d expected=0", tick_q.size()); end
        checks++; if (score_q.size() != 0) begin errors++; $display("FAIL score_queue_left: got=%0d expected=0", score_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
